// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: state encoding and control-pin reset levels shared by the PD sequencer
package pwr_seq_pkg;
  typedef enum logic [3:0] {
    ST_ON, ST_DN_CLK, ST_DN_ISO, ST_DN_RET, ST_DN_RST, ST_DN_PWR,
    ST_OFF, ST_UP_PWR, ST_UP_RST, ST_UP_RET, ST_UP_ISO, ST_UP_CLK
  } seq_state_t;
  localparam logic RST_CLK_EN     = 1'b0;
  localparam logic RST_ISO        = 1'b1;
  localparam logic RST_RET        = 1'b0;
  localparam logic RST_RSTN       = 1'b0;
  localparam logic RST_PWR_ON_REQ = 1'b1;
endpackage

// File: rtl/pwr_seq_timer.sv
// pwr_seq_timer: loadable down-counter that flags expiry once it reaches zero
module pwr_seq_timer #(
  parameter int W = 8
) (
  input  logic         i_aon_clk,
  input  logic         i_soc_pwr_on_rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins; otherwise count down and park at zero
  always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // count register
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst)
    if (i_soc_pwr_on_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/pd_pwr_sequencer.sv
// pd_pwr_sequencer: orders clock-gate, isolation, retention, reset and power-switch controls for one domain
module pd_pwr_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int DLY_W = 8,
  parameter int TO_W  = 12
) (
  input  logic             i_aon_clk,
  input  logic             i_soc_pwr_on_rst,
  input  logic             i_sleep_cmd,
  input  logic             i_wake_cmd,
  input  logic             i_pwrgate_en,
  input  logic [DLY_W-1:0] i_step_dly,
  input  logic [TO_W-1:0]  i_ack_timeout,
  input  logic             i_pwr_on_ack,
  input  logic             i_err_clr,
  output logic             o_clk_en,
  output logic             o_iso,
  output logic             o_ret,
  output logic             o_rstn,
  output logic             o_pwr_on_req,
  output logic             o_pd_on,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_timeout
);
  seq_state_t state_q, state_d;
  logic mode_q, to_en_q, err_q;
  logic clk_en_q, iso_q, ret_q, rstn_q, pwr_on_req_q, pd_on_q, busy_q, done_q;
  logic step_chg, step_exp, to_exp, in_wait, ack_ok, timeout, rest_d;
  assign step_chg = state_d != state_q;
  assign in_wait  = state_q inside {ST_DN_PWR, ST_UP_PWR};
  assign ack_ok   = (state_q == ST_UP_PWR) == i_pwr_on_ack;
  assign timeout  = in_wait && !ack_ok && to_exp && to_en_q;
  assign rest_d   = state_q inside {ST_ON, ST_OFF};
  pwr_seq_timer #(.W(DLY_W)) u_step (
    .i_aon_clk(i_aon_clk), .i_soc_pwr_on_rst(i_soc_pwr_on_rst),
    .load_i(step_chg), .val_i(i_step_dly), .dec_i(1'b1), .expired_o(step_exp)
  );
  pwr_seq_timer #(.W(TO_W)) u_to (
    .i_aon_clk(i_aon_clk), .i_soc_pwr_on_rst(i_soc_pwr_on_rst),
    .load_i(step_chg), .val_i(i_ack_timeout), .dec_i(in_wait && !ack_ok), .expired_o(to_exp)
  );
  // next state: timed steps advance on step expiry, wait steps on ack or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ON:     if (i_sleep_cmd && !i_wake_cmd) state_d = ST_DN_CLK;
      ST_DN_CLK: if (step_exp) state_d = ST_DN_ISO;
      ST_DN_ISO: if (step_exp) state_d = mode_q ? ST_DN_RET : ST_DN_RST;
      ST_DN_RET: if (step_exp) state_d = ST_DN_RST;
      ST_DN_RST: if (step_exp) state_d = mode_q ? ST_DN_PWR : ST_OFF;
      ST_DN_PWR: state_d = ack_ok ? ST_OFF : timeout ? ST_UP_PWR : ST_DN_PWR;
      ST_OFF:    if (i_wake_cmd) state_d = mode_q ? ST_UP_PWR : ST_UP_RST;
      ST_UP_PWR: if (ack_ok) state_d = ST_UP_RST;
      ST_UP_RST: if (step_exp) state_d = mode_q ? ST_UP_RET : ST_UP_ISO;
      ST_UP_RET: if (step_exp) state_d = ST_UP_ISO;
      ST_UP_ISO: if (step_exp) state_d = ST_UP_CLK;
      ST_UP_CLK: if (step_exp) state_d = ST_ON;
      default:   state_d = ST_UP_PWR;
    endcase
  end
  // state, gating mode latched on leaving ON, timeout arm flag and sticky error (set beats clear)
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst)
    if (i_soc_pwr_on_rst) begin
      state_q <= ST_UP_PWR;
      mode_q  <= 1'b1;
      to_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ON && step_chg) mode_q <= i_pwrgate_en;
      to_en_q <= step_chg ? (i_ack_timeout != '0) : (to_en_q && !timeout);
      err_q   <= timeout || (err_q && !i_err_clr);
    end
  // control pins follow the current step one clock later; untouched pins hold their level
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst)
    if (i_soc_pwr_on_rst) begin
      clk_en_q     <= RST_CLK_EN;
      iso_q        <= RST_ISO;
      ret_q        <= RST_RET;
      rstn_q       <= RST_RSTN;
      pwr_on_req_q <= RST_PWR_ON_REQ;
      pd_on_q      <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      clk_en_q     <= state_q == ST_DN_CLK ? 1'b0 : state_q == ST_UP_CLK ? 1'b1 : clk_en_q;
      iso_q        <= state_q == ST_DN_ISO ? 1'b1 : state_q == ST_UP_ISO ? 1'b0 : iso_q;
      ret_q        <= state_q == ST_DN_RET ? 1'b1 : state_q == ST_UP_RET ? 1'b0 : ret_q;
      rstn_q       <= state_q == ST_DN_RST ? 1'b0 : state_q == ST_UP_RST ? 1'b1 : rstn_q;
      pwr_on_req_q <= state_q == ST_DN_PWR ? 1'b0 : state_q == ST_UP_PWR ? 1'b1 : pwr_on_req_q;
      pd_on_q      <= state_q == ST_ON;
      busy_q       <= !rest_d;
      done_q       <= rest_d && busy_q;
    end
  assign o_clk_en      = clk_en_q;
  assign o_iso         = iso_q;
  assign o_ret         = ret_q;
  assign o_rstn        = rstn_q;
  assign o_pwr_on_req  = pwr_on_req_q;
  assign o_pd_on       = pd_on_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err_timeout = err_q;
endmodule

// File: tb/tb_pd_pwr_sequencer.sv
// tb_pd_pwr_sequencer: table, directed and randomized checks of the PD power sequencer
module tb_pd_pwr_sequencer;
  localparam int DLY_W = 8;
  localparam int TO_W  = 12;
  logic clk = 1'b0, rst = 1'b0, sleep = 1'b0, wake = 1'b0, gate = 1'b1, ack = 1'b0, err_clr = 1'b0;
  logic [DLY_W-1:0] dly = '0;
  logic [TO_W-1:0] ack_to = '0;
  logic clk_en, iso, ret, rstn, pwr_req, pd_on, busy, done, err;
  int total = 0, bad = 0, cyc = 0, lat = 3, done_cnt = 0;
  bit ack_auto = 0, rec = 0, ack_man = 0;
  logic [7:0] hist = '0;
  int ev_t[$], ev_i[$], ev_v[$];
  typedef struct {
    logic s, w, g;
    bit dn;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  pd_pwr_sequencer #(.DLY_W(DLY_W), .TO_W(TO_W)) dut (
    .i_aon_clk(clk), .i_soc_pwr_on_rst(rst), .i_sleep_cmd(sleep), .i_wake_cmd(wake),
    .i_pwrgate_en(gate), .i_step_dly(dly), .i_ack_timeout(ack_to), .i_pwr_on_ack(ack),
    .i_err_clr(err_clr), .o_clk_en(clk_en), .o_iso(iso), .o_ret(ret), .o_rstn(rstn),
    .o_pwr_on_req(pwr_req), .o_pd_on(pd_on), .o_busy(busy), .o_done(done), .o_err_timeout(err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // negedge monitor: logs control-pin changes and drives the rail model (ack follows req after lat cycles)
  initial begin : mon
    logic [4:0] prev, cur;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {clk_en, iso, ret, rstn, pwr_req};
      if (rec)
        for (int k = 0; k < 5; k++)
          if (cur[k] != prev[k]) begin
            ev_t.push_back(cyc); ev_i.push_back(4 - k); ev_v.push_back(int'(cur[k]));
          end
      prev = cur;
      if (done) done_cnt++;
      hist = ack_auto ? {hist[6:0], pwr_req} : {8{pwr_req}};
      ack = ack_auto ? hist[lat-1] : ack_man;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return clk_en;
      1: return iso;
      2: return ret;
      3: return rstn;
      4: return pwr_req;
      5: return busy;
      default: return err;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic v, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin @(negedge clk); ok = sig(s) == v; end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin @(negedge clk); ok = done; end
  endtask

  function automatic int find(input int i, input int v);
    foreach (ev_i[k]) if (ev_i[k] == i && ev_v[k] == v) return ev_t[k];
    return -1000;
  endfunction

  function automatic logic [7:0] outs();
    return {clk_en, iso, ret, rstn, pwr_req, pd_on, busy, err};
  endfunction

  function automatic logic [8:0] rvec();
    return {clk_en, iso, ret, rstn, pwr_req, pd_on, busy, done, err};
  endfunction

  // start a sequence with a command pulse held until the FSM has left its rest state
  task automatic kick(input bit up, output bit ok);
    if (up) wake = 1'b1; else sleep = 1'b1;
    wait_sig(5, 1'b1, 10, ok);
    sleep = 1'b0;
    wake = 1'b0;
  endtask

  initial begin
    bit ok;
    int c1, c2, cnt, first, d, g, n;
    int e_i[$], e_v[$];
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h60};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h9C};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h48};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h9C};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h9C};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h60};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h60};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h9C};

    #1 rst = 1'b1;
    #1 chk("reset_vals", int'(rvec()), 9'h094);

    // bring-up after reset: ack 3 cycles after release, 3-cycle step spacing, ret never moves
    dly = 2;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ev_t.delete(); ev_i.delete(); ev_v.delete();
    rec = 1; done_cnt = 0;
    cycles(3);
    ack_man = 1'b1;
    wait_done(100, ok);
    chk("bringup_done", ok, 1);
    cycles(3);
    rec = 0;
    chk("bringup_nev", ev_i.size(), 3);
    chk("bringup_iso_gap", find(1, 0) - find(3, 1), 6);
    chk("bringup_clk_gap", find(0, 1) - find(1, 0), 3);
    chk("bringup_done_cnt", done_cnt, 1);
    chk("bringup_on", int'(outs()), 8'h9C);

    // command table with the rail model answering acks
    ack_auto = 1; dly = 1;
    foreach (tbl[r]) begin
      sleep = tbl[r].s; wake = tbl[r].w; gate = tbl[r].g;
      ev_t.delete(); ev_i.delete(); ev_v.delete();
      rec = 1; n = done_cnt;
      if (tbl[r].dn) begin
        wait_done(400, ok);
        chk($sformatf("row%0d_done", r), ok, 1);
        cycles(2);
      end else begin
        cycles(40);
        chk($sformatf("row%0d_quiet", r), ev_i.size() + done_cnt - n, 0);
      end
      rec = 0;
      chk($sformatf("row%0d_outs", r), int'(outs()), int'(tbl[r].exp));
    end
    sleep = 1'b0; wake = 1'b0;

    // randomized down/up pairs checked against the step-order rules
    for (int it = 0; it < 12; it++) begin
      d = $urandom_range(0, 3); g = $urandom_range(0, 1); lat = $urandom_range(1, 6);
      dly = DLY_W'(d); gate = g[0];
      for (int ph = 0; ph < 2; ph++) begin
        e_i.delete(); e_v.delete();
        if (ph == 0 && g == 1) begin e_i = '{0, 1, 2, 3, 4}; e_v = '{0, 1, 1, 0, 0}; end
        if (ph == 0 && g == 0) begin e_i = '{0, 1, 3}; e_v = '{0, 1, 0}; end
        if (ph == 1 && g == 1) begin e_i = '{4, 3, 2, 1, 0}; e_v = '{1, 1, 0, 0, 1}; end
        if (ph == 1 && g == 0) begin e_i = '{3, 1, 0}; e_v = '{1, 0, 1}; end
        ev_t.delete(); ev_i.delete(); ev_v.delete();
        rec = 1;
        kick(ph == 1, ok);
        gate = 1'($urandom_range(0, 1));
        chk("rnd_start", ok, 1);
        wait_done(400, ok);
        rec = 0;
        chk("rnd_done", ok, 1);
        chk("rnd_nev", ev_i.size(), e_i.size());
        for (int k = 0; k < e_i.size() && k < ev_i.size(); k++) begin
          chk($sformatf("rnd%0d_%0d_pin%0d", it, ph, k), ev_i[k], e_i[k]);
          chk($sformatf("rnd%0d_%0d_val%0d", it, ph, k), ev_v[k], e_v[k]);
          if (k > 0 && !(ph == 1 && g == 1 && k == 1))
            chk($sformatf("rnd%0d_%0d_gap%0d", it, ph, k), ev_t[k] - ev_t[k-1], d + 1);
        end
        chk("rnd_state", {pd_on, busy, err}, ph == 1 ? 3'b100 : 3'b000);
      end
    end
    lat = 3;

    // wake during DN_ISO: down finishes, OFF lasts one cycle, up starts right after
    dly = 3; gate = 1'b1;
    kick(0, ok);
    wait_sig(1, 1'b1, 50, ok);
    chk("midwake_iso", ok, 1);
    wake = 1'b1;
    wait_done(200, ok);
    chk("midwake_off", {ok, busy, pd_on}, 3'b100);
    @(negedge clk);
    chk("midwake_up", {busy, pwr_req}, 2'b11);
    wait_done(200, ok);
    wake = 1'b0;
    chk("midwake_on", {ok, pd_on}, 2'b11);

    // DN_PWR timeout with ack stuck high: error 10 cycles after req drops, recovery to ON
    ack_man = 1'b1; ack_auto = 0; ack_to = 10; dly = 0;
    kick(0, ok);
    wait_sig(4, 1'b0, 50, ok);
    c1 = cyc;
    wait_sig(6, 1'b1, 50, ok);
    c2 = cyc;
    chk("dnto_delay", c2 - c1, 10);
    wait_done(100, ok);
    chk("dnto_on", {ok, pd_on, err}, 3'b111);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("dnto_clr", err, 0);

    // UP_PWR timeout with clear held: set wins for one cycle, request stays high, no re-fire
    ack_auto = 1; ack_to = 0;
    kick(0, ok);
    wait_done(200, ok);
    chk("upto_off", {ok, pd_on}, 2'b10);
    ack_man = 1'b0; ack_auto = 0; ack_to = 5; err_clr = 1'b1; wake = 1'b1;
    wait_sig(4, 1'b1, 20, ok);
    c1 = cyc; cnt = 0; first = -1;
    repeat (40) begin
      @(negedge clk);
      if (err) begin cnt++; if (first < 0) first = cyc; end
    end
    chk("upto_delay", first - c1, 5);
    chk("upto_pulses", cnt, 1);
    chk("upto_wait", {busy, pwr_req, rstn}, 3'b110);
    err_clr = 1'b0; ack_man = 1'b1;
    wait_done(100, ok);
    wake = 1'b0;
    chk("upto_on", {ok, pd_on, err}, 3'b110);

    // async reset in DN_RET: reset levels appear immediately, then waits in UP_PWR for ack
    ack_auto = 1; ack_to = 0; dly = 4;
    kick(0, ok);
    wait_sig(2, 1'b1, 100, ok);
    chk("arst_ret", ok, 1);
    #2 rst = 1'b1;
    #1 chk("arst_vals", int'(rvec()), 9'h094);
    ack_man = 1'b0; ack_auto = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cycles(20);
    chk("arst_wait", {busy, rstn, pwr_req, pd_on}, 4'b1010);
    ack_man = 1'b1;
    wait_done(100, ok);
    chk("arst_on", {ok, pd_on}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
